// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mmu_pkg
//  Purpose  : Shared definitions for the L1 MMU port: arbiter state encoding,
//             owner codes and default address / line widths reused by l1mmu
//             and the L1 caches.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mmu_pkg;

   localparam int MMU_ADDR_W = 32;
   localparam int MMU_LINE_W = 256;

   // State encoding doubles as the owner code so arb_owner is a direct view.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2
   } arb_state_e;

   localparam logic [1:0] OWNER_NONE = 2'b00;
   localparam logic [1:0] OWNER_I    = 2'b01;
   localparam logic [1:0] OWNER_D    = 2'b10;

endpackage : mmu_pkg
`default_nettype wire

// File: rtl/mmu_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mmu_port_arbiter
//  Purpose  : Registered, locking arbiter sharing the single L1 MMU request
//             port between the I-fetch path and the L1 data cache. I-side has
//             default priority; a starvation counter forces a D grant after
//             STARVE_LIMIT consecutive I grants taken while D was waiting.
//             The winning command is latched and held stable until mmu_done.
//  Ports    : sys_clk, rst_n (async, active-low)
//             immu_read/immu_addr -> immu_done/immu_read_data   (I-side)
//             dmmu_read/dmmu_write/dmmu_addr/dmmu_write_data
//                                  -> dmmu_done/dmmu_read_data  (D-side)
//             mmu_read/mmu_write/mmu_addr/mmu_write_data -> l1mmu
//             mmu_done/mmu_read_data <- l1mmu
//             arb_owner : 00 idle, 01 I, 10 D (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module mmu_port_arbiter
   import mmu_pkg::*;
#(
   parameter int ADDR_W       = MMU_ADDR_W,
   parameter int LINE_W       = MMU_LINE_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   // I-side
   input  logic              immu_read,
   input  logic [ADDR_W-1:0] immu_addr,
   output logic              immu_done,
   output logic [LINE_W-1:0] immu_read_data,
   // D-side
   input  logic              dmmu_read,
   input  logic              dmmu_write,
   input  logic [ADDR_W-1:0] dmmu_addr,
   input  logic [LINE_W-1:0] dmmu_write_data,
   output logic              dmmu_done,
   output logic [LINE_W-1:0] dmmu_read_data,
   // l1mmu
   output logic              mmu_read,
   output logic              mmu_write,
   output logic [ADDR_W-1:0] mmu_addr,
   output logic [LINE_W-1:0] mmu_write_data,
   input  logic              mmu_done,
   input  logic [LINE_W-1:0] mmu_read_data,
   // debug
   output logic [1:0]        arb_owner
);

   localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

   arb_state_e          r_state;
   logic [c_CNT_W-1:0]  r_starve_cnt;
   logic [ADDR_W-1:0]   r_cmd_addr;
   logic                r_cmd_rd;
   logic                r_cmd_wr;
   logic [LINE_W-1:0]   r_cmd_wdata;

   logic                w_d_req;
   logic                w_d_forced;

   assign w_d_req    = dmmu_read | dmmu_write;
   // D wins a simultaneous request only once I has used up its run.
   assign w_d_forced = w_d_req && (r_starve_cnt == c_LIMIT);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_starve_cnt <= '0;
         r_cmd_addr   <= '0;
         r_cmd_rd     <= 1'b0;
         r_cmd_wr     <= 1'b0;
         r_cmd_wdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (immu_read && !w_d_forced) begin
                  r_state     <= ST_BUSY_I;
                  r_cmd_addr  <= immu_addr;
                  r_cmd_rd    <= 1'b1;
                  r_cmd_wr    <= 1'b0;
                  r_cmd_wdata <= '0;
                  if (!w_d_req)
                     r_starve_cnt <= '0;
                  else if (r_starve_cnt != c_LIMIT)
                     r_starve_cnt <= r_starve_cnt + 1'b1;
               end else if (w_d_req) begin
                  r_state      <= ST_BUSY_D;
                  r_cmd_addr   <= dmmu_addr;
                  r_cmd_rd     <= dmmu_read;
                  r_cmd_wr     <= dmmu_write;
                  r_cmd_wdata  <= dmmu_write_data;
                  r_starve_cnt <= '0;
               end
            end
            ST_BUSY_I, ST_BUSY_D: begin
               // Command strobes drop with the transaction; address and data
               // keep their last value, which the MMU ignores without a strobe.
               if (mmu_done) begin
                  r_state  <= ST_IDLE;
                  r_cmd_rd <= 1'b0;
                  r_cmd_wr <= 1'b0;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_cmd_rd <= 1'b0;
               r_cmd_wr <= 1'b0;
            end
         endcase
      end
   end

   assign mmu_read       = r_cmd_rd;
   assign mmu_write      = r_cmd_wr;
   assign mmu_addr       = r_cmd_addr;
   assign mmu_write_data = r_cmd_wdata;

   // Done is a zero-cycle pass-through steered to the current owner only.
   assign immu_done = (r_state == ST_BUSY_I) && mmu_done;
   assign dmmu_done = (r_state == ST_BUSY_D) && mmu_done;

   assign immu_read_data = mmu_read_data;
   assign dmmu_read_data = mmu_read_data;

   always_comb begin
      arb_owner = OWNER_NONE;
      case (r_state)
         ST_BUSY_I: arb_owner = OWNER_I;
         ST_BUSY_D: arb_owner = OWNER_D;
         default:   arb_owner = OWNER_NONE;
      endcase
   end

endmodule : mmu_port_arbiter
`default_nettype wire

// File: tb/tb_mmu_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmu_port_arbiter
//  Purpose  : Directed self-checking bench for mmu_port_arbiter
//             (STARVE_LIMIT = 4, 32-bit address, 256-bit line).
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmu_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              sys_clk = 1'b0;
   logic              rst_n;
   logic              immu_read;
   logic [ADDR_W-1:0] immu_addr;
   logic              immu_done;
   logic [LINE_W-1:0] immu_read_data;
   logic              dmmu_read;
   logic              dmmu_write;
   logic [ADDR_W-1:0] dmmu_addr;
   logic [LINE_W-1:0] dmmu_write_data;
   logic              dmmu_done;
   logic [LINE_W-1:0] dmmu_read_data;
   logic              mmu_read;
   logic              mmu_write;
   logic [ADDR_W-1:0] mmu_addr;
   logic [LINE_W-1:0] mmu_write_data;
   logic              mmu_done;
   logic [LINE_W-1:0] mmu_read_data;
   logic [1:0]        arb_owner;

   int r_checks   = 0;
   int r_failures = 0;

   mmu_port_arbiter #(
      .ADDR_W       (ADDR_W),
      .LINE_W       (LINE_W),
      .STARVE_LIMIT (4)
   ) dut (
      .sys_clk         (sys_clk),
      .rst_n           (rst_n),
      .immu_read       (immu_read),
      .immu_addr       (immu_addr),
      .immu_done       (immu_done),
      .immu_read_data  (immu_read_data),
      .dmmu_read       (dmmu_read),
      .dmmu_write      (dmmu_write),
      .dmmu_addr       (dmmu_addr),
      .dmmu_write_data (dmmu_write_data),
      .dmmu_done       (dmmu_done),
      .dmmu_read_data  (dmmu_read_data),
      .mmu_read        (mmu_read),
      .mmu_write       (mmu_write),
      .mmu_addr        (mmu_addr),
      .mmu_write_data  (mmu_write_data),
      .mmu_done        (mmu_done),
      .mmu_read_data   (mmu_read_data),
      .arb_owner       (arb_owner)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [LINE_W-1:0] got,
                        input logic [LINE_W-1:0] exp);
      r_checks++;
      if (got !== exp) begin
         r_failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   logic [LINE_W-1:0] c_wdata;
   logic [1:0]        r_exp_owner [6];
   logic [2:0]        r_exp_cnt   [6];

   initial begin
      c_wdata = {8{32'hA5A5_0001}};
      r_exp_owner = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
      r_exp_cnt   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

      rst_n = 1'b0; immu_read = 1'b0; immu_addr = '0;
      dmmu_read = 1'b0; dmmu_write = 1'b0; dmmu_addr = '0; dmmu_write_data = '0;
      mmu_done = 1'b0; mmu_read_data = '0;
      #1;
      // ---------------- reset state
      check("rst_mmu_read",  LINE_W'(mmu_read),  '0);
      check("rst_mmu_write", LINE_W'(mmu_write), '0);
      check("rst_mmu_addr",  LINE_W'(mmu_addr),  '0);
      check("rst_owner",     LINE_W'(arb_owner), '0);
      step(); step();
      rst_n = 1'b1;
      step();
      check("rst_starve", LINE_W'(dut.r_starve_cnt), '0);

      // ---------------- I-only read, done on 6th busy cycle
      immu_read = 1'b1; immu_addr = 32'h0040_0100;
      step();
      immu_read = 1'b1;
      check("i_rd",    LINE_W'(mmu_read),  1);
      check("i_wr",    LINE_W'(mmu_write), 0);
      check("i_addr",  LINE_W'(mmu_addr),  LINE_W'(32'h0040_0100));
      check("i_owner", LINE_W'(arb_owner), 1);
      repeat (5) step();
      mmu_done = 1'b1; mmu_read_data = {8{32'hDEAD_BEEF}};
      #1;
      check("i_done",   LINE_W'(immu_done), 1);
      check("i_ddone",  LINE_W'(dmmu_done), 0);
      check("i_rdata",  immu_read_data, {8{32'hDEAD_BEEF}});
      check("d_rdata",  dmmu_read_data, {8{32'hDEAD_BEEF}});
      step();
      mmu_done = 1'b0; immu_read = 1'b0;
      check("i_idle_owner", LINE_W'(arb_owner), 0);
      check("i_idle_rd",    LINE_W'(mmu_read),  0);
      step();

      // ---------------- D write
      dmmu_write = 1'b1; dmmu_addr = 32'h1000_0020; dmmu_write_data = c_wdata;
      step();
      check("dw_wr",    LINE_W'(mmu_write), 1);
      check("dw_rd",    LINE_W'(mmu_read),  0);
      check("dw_addr",  LINE_W'(mmu_addr),  LINE_W'(32'h1000_0020));
      check("dw_data",  mmu_write_data,     c_wdata);
      check("dw_owner", LINE_W'(arb_owner), 2);
      step();
      mmu_done = 1'b1;
      #1;
      check("dw_done",  LINE_W'(dmmu_done), 1);
      check("dw_idone", LINE_W'(immu_done), 0);
      step();
      mmu_done = 1'b0; dmmu_write = 1'b0;
      check("dw_idle", LINE_W'(arb_owner), 0);
      check("dw_wr_off", LINE_W'(mmu_write), 0);
      step();

      // ---------------- simultaneous, I first then D
      immu_read = 1'b1; immu_addr = 32'h0040_0200;
      dmmu_read = 1'b1; dmmu_addr = 32'h2000_0040;
      step();
      check("sim_owner_i", LINE_W'(arb_owner), 1);
      check("sim_cnt_i",   LINE_W'(dut.r_starve_cnt), 1);
      check("sim_addr_i",  LINE_W'(mmu_addr), LINE_W'(32'h0040_0200));
      check("sim_wdata_i", mmu_write_data, '0);
      mmu_done = 1'b1;
      step();
      mmu_done = 1'b0; immu_read = 1'b0;
      check("sim_gap", LINE_W'(arb_owner), 0);
      step();
      check("sim_owner_d", LINE_W'(arb_owner), 2);
      check("sim_cnt_d",   LINE_W'(dut.r_starve_cnt), 0);
      check("sim_addr_d",  LINE_W'(mmu_addr), LINE_W'(32'h2000_0040));
      check("sim_rd_d",    LINE_W'(mmu_read), 1);
      mmu_done = 1'b1;
      step();
      mmu_done = 1'b0; dmmu_read = 1'b0;
      step();

      // ---------------- starvation: both held, 3-cycle transactions
      immu_read = 1'b1; dmmu_read = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("stv_owner%0d", k), LINE_W'(arb_owner), LINE_W'(r_exp_owner[k]));
         check($sformatf("stv_cnt%0d", k), LINE_W'(dut.r_starve_cnt), LINE_W'(r_exp_cnt[k]));
         step(); step();
         mmu_done = 1'b1;
         step();
         mmu_done = 1'b0;
         if (k == 5) begin
            immu_read = 1'b0; dmmu_read = 1'b0;
         end
      end
      step();

      // ---------------- I drops request mid-transaction, spurious done
      immu_read = 1'b1; immu_addr = 32'h0040_0300;
      step();
      immu_read = 1'b0; immu_addr = 32'h0;
      step();
      check("drop_rd",   LINE_W'(mmu_read), 1);
      check("drop_addr", LINE_W'(mmu_addr), LINE_W'(32'h0040_0300));
      mmu_done = 1'b1;
      #1;
      check("drop_done", LINE_W'(immu_done), 1);
      step();
      check("drop_idle", LINE_W'(arb_owner), 0);
      check("spur_idone", LINE_W'(immu_done), 0);
      check("spur_ddone", LINE_W'(dmmu_done), 0);
      step();
      check("spur_owner", LINE_W'(arb_owner), 0);
      mmu_done = 1'b0;
      step();

      // ---------------- async reset mid BUSY_D
      dmmu_read = 1'b1; dmmu_addr = 32'h3000_0080;
      step();
      check("rd_busy", LINE_W'(arb_owner), 2);
      dmmu_read = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      mmu_done = 1'b1;
      #1;
      check("ar_rd",    LINE_W'(mmu_read),  0);
      check("ar_addr",  LINE_W'(mmu_addr),  0);
      check("ar_owner", LINE_W'(arb_owner), 0);
      check("ar_ddone", LINE_W'(dmmu_done), 0);
      mmu_done = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      immu_read = 1'b1; immu_addr = 32'h0040_0400;
      step();
      check("post_owner", LINE_W'(arb_owner), 1);
      check("post_addr",  LINE_W'(mmu_addr),  LINE_W'(32'h0040_0400));
      mmu_done = 1'b1;
      #1;
      check("post_done", LINE_W'(immu_done), 1);
      step();
      mmu_done = 1'b0; immu_read = 1'b0;
      check("post_idle", LINE_W'(arb_owner), 0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", r_checks, r_failures);
      $finish;
   end

endmodule : tb_mmu_port_arbiter
`default_nettype wire

// File: doc/mmu_port_arbiter.md
# mmu_port_arbiter

Registered, locking arbiter that shares the single L1 MMU request port between the L1 instruction fetch path (I-side) and the L1 data cache (D-side). It sits between the L1I/L1D miss interfaces and `l1mmu`, replacing the combinational I-priority mux in `top`. I-side keeps default priority, but a starvation counter forces a D grant after a bounded run of I grants. Each granted request is latched, so the MMU sees a stable command for the whole transaction.

## Interface
- `ADDR_W`, 32, address width
- `LINE_W`, 256, cache-line data width
- `STARVE_LIMIT`, 4, consecutive I grants allowed while D waits (≥1)

Ports:
- `sys_clk` in 1: system clock
- `rst_n` in 1: one clock; reset is asynchronous and active-low
- `immu_read` in 1: I-side line read request; level, held until `immu_done`
- `immu_addr` in ADDR_W: I-side line address
- `immu_done` out 1: one-cycle completion pulse to I-side
- `immu_read_data` out LINE_W: returned line, valid when `immu_done`=1
- `dmmu_read`, `dmmu_write` in 1: D-side requests; level, held until `dmmu_done`, never both 1
- `dmmu_addr` in ADDR_W, `dmmu_write_data` in LINE_W: D-side command
- `dmmu_done` out 1; `dmmu_read_data` out LINE_W
- `mmu_read`, `mmu_write` out 1; `mmu_addr` out ADDR_W; `mmu_write_data` out LINE_W: to `l1mmu`
- `mmu_done` in 1; `mmu_read_data` in LINE_W: from `l1mmu`
- `arb_owner` out 2: 00 idle, 01 I, 10 D (debug)

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: `mmu_read`=`mmu_write`=0. On the clock edge with a pending request:
  - I only → BUSY_I.
  - D only → BUSY_D.
  - Both, `starve_cnt` < STARVE_LIMIT → BUSY_I.
  - Both, `starve_cnt` == STARVE_LIMIT → BUSY_D.
- On grant, latch `cmd_addr`, `cmd_rd`, `cmd_wr`, `cmd_wdata` from the winner. I grants always latch rd=1, wr=0, wdata=0.
- BUSY_x:
  - `mmu_*` outputs are driven from the latched registers.
  - On `mmu_done`=1: pulse the owner's done in the same cycle (combinational, `state` & `mmu_done`), then → IDLE.
  - The command stays latched until `mmu_done`, even if the requester deasserts. The done pulse is still issued; the requester ignores it.
- `immu_read_data` and `dmmu_read_data` are both wired directly to `mmu_read_data`. Only the done strobe is steered.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - I grant while a D request is pending → +1, saturating.
  - I grant with no D request → 0.
  - D grant → 0.
- `mmu_done` in IDLE is ignored: no done pulse, no state change.
- Reset (async): state IDLE, `starve_cnt`=0, latched cmd=0. All outputs are 0 during and after reset until the next grant.
- Reset mid-transaction aborts without a done pulse; `l1mmu` shares `rst_n`.

## Timing
- Request-to-`mmu_*` latency: 1 cycle (request seen at edge N → `mmu_read`/`mmu_write` high from cycle N+1).
- Done: zero-cycle pass-through from `mmu_done`.
- Back-to-back: at least one IDLE cycle between transactions. Requesters drop their request in the cycle after done, so IDLE never re-grants a completed request.
- `mmu_*` outputs are stable from grant to done. The MMU may assume no mid-transaction change.
- Worst-case D wait, with I continuously requesting: STARVE_LIMIT I transactions plus the current one.

## Structure
- Shared package `mmu_pkg`:
  - state encoding (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2);
  - owner codes;
  - `LINE_W`/`ADDR_W` defaults, reused by `l1mmu` and the L1 caches.
- Single module, no sub-module. Arbitration, counter and command latch total about 150 lines.
- `top` instantiates it in place of the `serve_ic` mux.

## Test plan
- I-only read: `immu_read`=1, `immu_addr`=0x0040_0100 at edge 0 → `mmu_read`=1 with `mmu_addr`=0x0040_0100 from cycle 1. `mmu_done` at cycle 6 → `immu_done`=1 at cycle 6, `dmmu_done`=0, `arb_owner`=00 at cycle 7.
- D write: `dmmu_write`=1, addr 0x1000_0020, data {8{32'hA5A5_0001}} → `mmu_write`=1, same addr/data, `mmu_read`=0. `dmmu_done` pulses with `mmu_done`.
- Simultaneous `immu_read` and `dmmu_read` from idle, `starve_cnt`=0 → I served first, one IDLE cycle, then D served. `starve_cnt` is 1 after the I grant and 0 after the D grant.
- Starvation, STARVE_LIMIT=4: `immu_read` and `dmmu_read` held high continuously, MMU completes each transaction in 3 cycles → grant order I,I,I,I,D,I…; `starve_cnt` saturates at 4.
- I requester drops `immu_read` during BUSY_I → `mmu_addr`/`mmu_read` stay latched. `immu_done` still pulses on `mmu_done`, then IDLE. A spurious `mmu_done` in IDLE produces no done pulse.
- `rst_n` asserted asynchronously mid BUSY_D → all outputs 0 immediately, `arb_owner`=00, no done pulse. After release, a fresh I request is granted normally.
